// File: rtl/cordic_rot_seq.sv
// Iterative rotation-mode CORDIC: quadrant fold followed by ITER shared-adder
// micro-rotations, with a valid/ready handshake on both sides.
module cordic_rot_seq #(
  parameter int WIDTH      = 16,
  parameter int WIDTH_WIRE = 18,
  parameter int ITER       = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [WIDTH_WIRE-1:0] x_in,
  input  logic signed [WIDTH_WIRE-1:0] y_in,
  input  logic        [WIDTH-1:0]      z_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [WIDTH_WIRE-1:0] x_out,
  output logic signed [WIDTH_WIRE-1:0] y_out,
  output logic                         angle_err,
  output logic                         busy
);

  localparam int CW = 4;
  localparam logic [CW-1:0] LAST_IT = CW'(ITER - 1);

  // Angle landmarks at 4096 LSB/rad.
  localparam logic [WIDTH-1:0] HALF_PI       = WIDTH'(6433);
  localparam logic [WIDTH-1:0] PI_ANG        = WIDTH'(12867);
  localparam logic [WIDTH-1:0] THREE_HALF_PI = WIDTH'(19301);
  localparam logic [WIDTH-1:0] TWO_PI        = WIDTH'(25735);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FOLD,
    S_ITER,
    S_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic signed [WIDTH_WIRE-1:0] x_q, x_d;
  logic signed [WIDTH_WIRE-1:0] y_q, y_d;
  logic signed [WIDTH:0]        z_q, z_d;
  logic signed [WIDTH_WIRE-1:0] xo_q, xo_d;
  logic signed [WIDTH_WIRE-1:0] yo_q, yo_d;
  logic        [CW-1:0]         i_q, i_d;
  logic                         err_q, err_d;

  logic        [WIDTH-1:0]      z_u;
  logic signed [WIDTH_WIRE-1:0] x_sh, y_sh;
  logic signed [WIDTH:0]        atan_i;

  function automatic logic signed [WIDTH:0] atan_lut(input logic [CW-1:0] idx);
    logic signed [WIDTH:0] v;
    v = '0;
    case (idx)
      4'd0:    v = (WIDTH+1)'(3217);
      4'd1:    v = (WIDTH+1)'(1899);
      4'd2:    v = (WIDTH+1)'(1003);
      4'd3:    v = (WIDTH+1)'(509);
      4'd4:    v = (WIDTH+1)'(256);
      4'd5:    v = (WIDTH+1)'(128);
      4'd6:    v = (WIDTH+1)'(64);
      4'd7:    v = (WIDTH+1)'(32);
      4'd8:    v = (WIDTH+1)'(16);
      4'd9:    v = (WIDTH+1)'(8);
      4'd10:   v = (WIDTH+1)'(4);
      4'd11:   v = (WIDTH+1)'(2);
      4'd12:   v = (WIDTH+1)'(1);
      default: v = '0;
    endcase
    return v;
  endfunction

  // The residual angle is non-negative until the micro-rotations start, so
  // its low WIDTH bits are the unsigned accepted angle during FOLD.
  assign z_u    = z_q[WIDTH-1:0];
  assign x_sh   = x_q >>> i_q;
  assign y_sh   = y_q >>> i_q;
  assign atan_i = atan_lut(i_q);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    i_d     = i_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = {1'b0, z_in};
          state_d = S_FOLD;
        end
      end

      S_FOLD: begin
        err_d   = 1'b0;
        i_d     = '0;
        state_d = S_ITER;
        if (z_u >= TWO_PI) begin
          z_d   = '0;
          err_d = 1'b1;
        end else if (z_u >= THREE_HALF_PI) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = z_q - {1'b0, THREE_HALF_PI};
        end else if (z_u >= PI_ANG) begin
          x_d = -x_q;
          y_d = -y_q;
          z_d = z_q - {1'b0, PI_ANG};
        end else if (z_u >= HALF_PI) begin
          x_d = -y_q;
          y_d = x_q;
          z_d = z_q - {1'b0, HALF_PI};
        end
      end

      S_ITER: begin
        if (!z_q[WIDTH]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end
        // Capture the result separately so it survives the next acceptance.
        if (i_q == LAST_IT) begin
          xo_d    = x_d;
          yo_d    = y_d;
          i_d     = '0;
          state_d = S_DONE;
        end else begin
          i_d = i_q + CW'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      i_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      i_q     <= i_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign x_out     = xo_q;
  assign y_out     = yo_q;
  assign angle_err = err_q;

endmodule

// File: tb/tb_cordic_rot_seq.sv
// Scoreboard bench for cordic_rot_seq: directed vectors push expected results,
// a negedge monitor pops and compares each time out_valid rises.
module tb_cordic_rot_seq;

  localparam int WIDTH      = 16;
  localparam int WIDTH_WIRE = 18;
  localparam int ITER       = 12;
  localparam int TOL        = 8;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [WIDTH_WIRE-1:0] x_in;
  logic signed [WIDTH_WIRE-1:0] y_in;
  logic        [WIDTH-1:0]      z_in;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [WIDTH_WIRE-1:0] x_out;
  logic signed [WIDTH_WIRE-1:0] y_out;
  logic                         angle_err;
  logic                         busy;

  cordic_rot_seq #(
    .WIDTH(WIDTH),
    .WIDTH_WIRE(WIDTH_WIRE),
    .ITER(ITER)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x_in(x_in),
    .y_in(y_in),
    .z_in(z_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out(x_out),
    .y_out(y_out),
    .angle_err(angle_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int n_exp    = 0;

  typedef struct {
    int x;
    int y;
    int err;
    int acc;
    int id;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input int act, input int expv, input int tol);
    checks++;
    if (act - expv > tol || expv - act > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", nm, act, expv, tol);
    end
  endtask

  // Monitor: one comparison set per rising out_valid.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: x=%0d y=%0d with empty scoreboard", x_out, y_out);
        end else begin
          e = sb.pop_front();
          chk($sformatf("x_out[%0d]", e.id), int'(x_out), e.x, TOL);
          chk($sformatf("y_out[%0d]", e.id), int'(y_out), e.y, TOL);
          chk($sformatf("angle_err[%0d]", e.id), int'(angle_err), e.err, 0);
          chk($sformatf("latency[%0d]", e.id), cyc - e.acc, ITER + 2, 0);
          done_cnt++;
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input int id, input int x, input int y, input int z,
                      input int ex, input int ey, input int eerr, input bit push);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = WIDTH_WIRE'(x);
    y_in     = WIDTH_WIRE'(y);
    z_in     = WIDTH'(z);
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout[%0d]: in_ready=%0d, expected 1", id, in_ready);
      in_valid = 1'b0;
    end else begin
      if (push) begin
        sb.push_back('{ex, ey, eerr, cyc, id});
        n_exp++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_results(input int n);
    int w;
    w = 0;
    while (done_cnt < n && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("results_seen", done_cnt, n, 0);
  endtask

  // Vectors: x, y, z, expected x_out, y_out, angle_err.
  int tv_x[7]  = '{10000, 10000, 10000, 10000,  10000,  10000, 10000};
  int tv_y[7]  = '{0,     0,     0,     0,      0,      5000,  0};
  int tv_z[7]  = '{0,     3217,  6433,  12867,  19301,  30000, 25735};
  int tv_ex[7] = '{16468, 11645, 0,     -16468, 0,      16468, 16468};
  int tv_ey[7] = '{0,     11645, 16468, 0,      -16468, 8234,  0};
  int tv_er[7] = '{0,     0,     0,     0,      0,      1,     1};

  initial begin
    int rose;
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    y_in      = '0;
    z_in      = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1, 0);
    chk("reset_out_valid", int'(out_valid), 0, 0);
    chk("reset_x_out", int'(x_out), 0, 0);
    chk("reset_y_out", int'(y_out), 0, 0);
    chk("reset_busy", int'(busy), 0, 0);
    chk("reset_angle_err", int'(angle_err), 0, 0);

    for (int k = 0; k < 7; k++) begin
      send(k, tv_x[k], tv_y[k], tv_z[k], tv_ex[k], tv_ey[k], tv_er[k], 1'b1);
      @(negedge clk);
      chk($sformatf("busy_running[%0d]", k), int'(busy), 1, 0);
      chk($sformatf("in_ready_running[%0d]", k), int'(in_ready), 0, 0);
      wait_results(n_exp);
    end

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    send(10, 10000, 0, 0, 16468, 0, 0, 1'b1);
    w = 0;
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("stall_valid_arrives", int'(out_valid), 1, 0);
    in_valid = 1'b1;
    x_in     = WIDTH_WIRE'(-20000);
    y_in     = WIDTH_WIRE'(1234);
    z_in     = WIDTH'(12867);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("stall_out_valid[%0d]", c), int'(out_valid), 1, 0);
      chk($sformatf("stall_in_ready[%0d]", c), int'(in_ready), 0, 0);
      chk($sformatf("stall_x_out[%0d]", c), int'(x_out), 16468, TOL);
      chk($sformatf("stall_y_out[%0d]", c), int'(y_out), 0, TOL);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_in_ready", int'(in_ready), 1, 0);
    chk("stall_release_out_valid", int'(out_valid), 0, 0);
    chk("hold_after_handshake_x", int'(x_out), 16468, TOL);
    wait_results(n_exp);

    // Abort: reset during the micro-rotations drops the sample.
    send(20, 10000, 0, 3217, 0, 0, 0, 1'b0);
    repeat (6) @(negedge clk);
    chk("abort_busy_before", int'(busy), 1, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", int'(in_ready), 1, 0);
    chk("abort_busy", int'(busy), 0, 0);
    chk("abort_x_out", int'(x_out), 0, 0);
    chk("abort_y_out", int'(y_out), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rose = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) rose = 1;
    end
    chk("abort_no_output", rose, 0, 0);
    chk("abort_idle", int'(in_ready), 1, 0);

    send(30, 10000, 0, 3217, 11645, 11645, 0, 1'b1);
    wait_results(n_exp);

    chk("scoreboard_empty", sb.size(), 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
